clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_W, default 4, SHALL set the width of divide-ratio fields.
REQ-002 Parameter DEF_DIV, default 7, SHALL set the divide ratio loaded at reset; legal range 2..2^DIV_W-1.
REQ-003 clk_in  input  1  SHALL be the single reference clock; all registers use it, rising edge unless REQ-015 states otherwise.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 run_en  input  1  SHALL be level enable; 1 requests divided output, 0 requests stop.
REQ-006 cfg_valid  input  1  SHALL indicate that a new ratio on cfg_div is offered.
REQ-007 cfg_div  input  DIV_W  SHALL carry the requested divide ratio N.
REQ-008 cfg_ready  output  1  SHALL indicate that the block can accept a ratio this cycle.
REQ-009 cfg_err  output  1  SHALL be a one-cycle pulse when an accepted ratio is illegal.
REQ-010 upd_done  output  1  SHALL be a one-cycle pulse when a pending ratio becomes active.
REQ-011 cur_div  output  DIV_W  SHALL show the active ratio.
REQ-012 busy  output  1  SHALL be high in RUN and DRAIN.
REQ-013 clk_out  output  1  SHALL be the divided clock.

Function
REQ-014 A period counter cnt SHALL run 0..N-1 in RUN/DRAIN and wrap to 0; the boundary cycle SHALL be cnt==N-1.
REQ-015 Phase register pos_q SHALL be 1 during cycle cnt==k iff k < ceil(N/2); even N: clk_out = pos_q; odd N: clk_out = pos_q AND neg_q, where neg_q is pos_q captured on the falling edge of clk_in; this gives exactly 50% duty, period N input cycles.
REQ-016 Handshake: transfer SHALL occur when cfg_valid AND cfg_ready at a rising edge; cfg_ready = NOT pend.
REQ-017 Accepted cfg_div < 2 SHALL be discarded, with cfg_err high the next cycle; pend and cur_div are unchanged.
REQ-018 Accepted legal cfg_div SHALL be stored in a pending register and set pend.
REQ-019 States SHALL be IDLE, RUN, DRAIN.
REQ-020 IDLE: cnt=0, clk_out=0, busy=0; on run_en=1 the state SHALL go to RUN, with cnt=0 and clk_out rising in the first RUN cycle.
REQ-021 RUN: if run_en=0, the state SHALL go to DRAIN.
REQ-022 DRAIN: at the boundary cycle the state SHALL go to IDLE; if run_en returns to 1 before the boundary, the state SHALL return to RUN without a gap or a change in cnt.
REQ-023 Pending in RUN/DRAIN SHALL load into cur_div only at the edge leaving the boundary cycle; in that same edge cnt becomes 0 and pend clears, and upd_done pulses the following cycle.
REQ-024 Pending in IDLE SHALL load at the next edge, with upd_done pulsing the following cycle.
REQ-025 A ratio accepted in the boundary cycle SHALL apply at the following boundary, not the current one.
REQ-026 clk_out SHALL never produce a high or low phase shorter than floor(min(N_old, N_new)/2) input cycles across a ratio change or a stop.
REQ-027 Stop SHALL complete the current period; clk_out SHALL end low.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, cnt=0, pos_q=neg_q=0, clk_out=0, cur_div=DEF_DIV, pend=0, cfg_ready=1, cfg_err=0, upd_done=0, busy=0.
REQ-029 Reset mid-period SHALL truncate the output asynchronously; after release, behaviour SHALL be as from power-up.

Structure
REQ-030 Shared package clk_div_pkg SHALL hold DIV_W, DEF_DIV, MIN_DIV=2 and the state enumeration.
REQ-031 Sub-module clk_div_core SHALL contain cnt, pos_q, neg_q and the output gate, taking ratio, run and load inputs.
REQ-032 clk_div_ctrl SHALL hold the FSM, the handshake and the pending register.
REQ-033 Target size SHALL be 150-300 lines of RTL total.

Verification
REQ-034 Reset, run_en=1, N=7 -> clk_out period 7, high 3.5 cycles, busy=1, cur_div=7.
REQ-035 RUN at N=7; cfg_div=4 accepted at cnt=2 -> cfg_ready=0 until the boundary, upd_done one cycle after it, then period 4 with high 2; no short pulse.
REQ-036 cfg_div=1 accepted -> cfg_err pulses once, cur_div stays 7, output unchanged.
REQ-037 cfg_div=5 accepted exactly at cnt==6 (N=7) -> one more period of 7, then period 5.
REQ-038 run_en=0 at cnt=1 -> period completes, IDLE, clk_out=0; run_en=1 pulsed during DRAIN -> continuous output.
REQ-039 rst=1 mid-high-phase -> clk_out=0 immediately; cur_div=DEF_DIV after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and state encoding for the programmable clock divider.
// Latency: n/a. Backpressure: n/a.
// Holds the default widths and ratios that the divider instances use.
package clk_div_pkg;

    localparam int DIV_W   = 4;
    localparam int DEF_DIV = 7;
    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and 50%-duty phase generator for a divide-by-N clock.
// Latency: output follows run_i by one rising edge. Backpressure: none; ratio/load are applied on the edge they are sampled.
// A ratio change is only requested by the controller at a period boundary or while stopped.
module clk_div_core #(
    parameter int DIV_W = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] ratio_i,
    input  logic [DIV_W-1:0] ratio_ld_i,
    input  logic             load_i,
    input  logic             run_i,
    output logic             boundary_o,
    output logic             clk_out_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic [DIV_W-1:0] ratio_n;
    logic [DIV_W:0]   half_up;

    assign boundary_o = run_q && (cnt_q == (ratio_i - DIV_W'(1)));

    always_comb begin
        ratio_n = load_i ? ratio_ld_i : ratio_i;
        half_up = ({1'b0, ratio_n} + (DIV_W+1)'(1)) >> 1;
        cnt_d   = '0;
        if (run_i && run_q && !boundary_o)
            cnt_d = cnt_q + DIV_W'(1);
        // High for the first ceil(N/2) counts of the period the next cycle belongs to.
        pos_d   = run_i && ({1'b0, cnt_d} < half_up);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            pos_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_i;
            pos_q <= pos_d;
        end
    end

    // Half-cycle delayed copy trims the extra half cycle off odd ratios.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q;
    end

    assign clk_out_o = ratio_i[0] ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop sequencing, ratio handshake and glitch-free ratio update for the clock divider.
// Latency: new ratio active at the edge leaving the next period boundary (next edge when idle).
// Backpressure: cfg_ready drops while a ratio is pending and rises once it has been applied.
module clk_div_ctrl #(
    parameter int DIV_W   = clk_div_pkg::DIV_W,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             upd_done,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy,
    output logic             clk_out
);

    import clk_div_pkg::*;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic             err_q, err_d;
    logic             upd_q, upd_d;
    logic             boundary;
    logic             accept;
    logic             load;
    logic             run_nxt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_en)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                // A stop requested on the boundary cycle has already completed its period.
                if (!run_en)
                    state_d = boundary ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (run_en)
                    state_d = ST_RUN;
                else if (boundary)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run_nxt   = (state_d != ST_IDLE);
        accept    = cfg_valid && !pend_q;
        load      = pend_q && ((state_q == ST_IDLE) || boundary);
        pend_d    = pend_q;
        pdiv_d    = pdiv_q;
        cur_div_d = cur_div_q;
        err_d     = 1'b0;
        upd_d     = load;
        if (load) begin
            cur_div_d = pdiv_q;
            pend_d    = 1'b0;
        end else if (accept) begin
            if (cfg_div < DIV_W'(MIN_DIV)) begin
                err_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                pdiv_d = cfg_div;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            pdiv_q    <= DIV_W'(DEF_DIV);
            cur_div_q <= DIV_W'(DEF_DIV);
            err_q     <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pdiv_q    <= pdiv_d;
            cur_div_q <= cur_div_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
        end
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk_in     (clk_in),
        .rst        (rst),
        .ratio_i    (cur_div_q),
        .ratio_ld_i (pdiv_q),
        .load_i     (load),
        .run_i      (run_nxt),
        .boundary_o (boundary),
        .clk_out_o  (clk_out)
    );

    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;
    assign upd_done  = upd_q;
    assign cur_div   = cur_div_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios then random traffic against a waveform-level model.
module tb_clk_div_ctrl;

    localparam int DIV_W   = 4;
    localparam int DEF_DIV = 7;

    logic             clk_in;
    logic             rst;
    logic             run_en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             upd_done;
    logic [DIV_W-1:0] cur_div;
    logic             busy;
    logic             clk_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: whether output is running, position k within the period, active ratio, pending ratio.
    bit m_on;
    int m_k;
    int m_n;
    bit m_pend;
    int m_pdiv;
    bit m_err;
    bit m_upd;

    clk_div_ctrl #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .upd_done  (upd_done),
        .cur_div   (cur_div),
        .busy      (busy),
        .clk_out   (clk_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // The divided clock is high for N half-cycles per period; odd ratios start it half a cycle late.
    function automatic int exp_clk(input int half);
        int h;
        if (!m_on) return 0;
        h = 2 * m_k + half;
        if (m_n % 2 == 1) return (h >= 1 && h <= m_n) ? 1 : 0;
        return (h < m_n) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_on = 0; m_k = 0; m_n = DEF_DIV; m_pend = 0; m_pdiv = 0; m_err = 0; m_upd = 0;
    endtask

    // One input clock cycle: advance model at the rising edge, check both halves of the cycle.
    task automatic cyc();
        bit eop, acc, ld, on_n;
        int k_n;
        @(posedge clk_in);
        eop  = m_on && (m_k == m_n - 1);
        acc  = cfg_valid && !m_pend;
        ld   = m_pend && (!m_on || eop);
        on_n = m_on ? (run_en || !eop) : run_en;
        k_n  = (on_n && m_on && !eop) ? m_k + 1 : 0;
        m_err = acc && (int'(cfg_div) < 2);
        m_upd = ld;
        if (ld) begin
            m_n = m_pdiv; m_pend = 0;
        end else if (acc && int'(cfg_div) >= 2) begin
            m_pend = 1; m_pdiv = int'(cfg_div);
        end
        m_on = on_n;
        m_k  = k_n;
        #1;
        chk("busy", int'(busy), int'(m_on));
        chk("cur_div", int'(cur_div), m_n);
        chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        chk("upd_done", int'(upd_done), int'(m_upd));
        chk("clk_out_h0", int'(clk_out), exp_clk(0));
        @(negedge clk_in);
        #1;
        chk("clk_out_h1", int'(clk_out), exp_clk(1));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_k(input int k);
        for (int i = 0; i < 40 && !(m_on && m_k == k); i++) cyc();
        chk("wait_k_reached", int'(m_on && m_k == k), 1);
    endtask

    task automatic offer(input int div);
        cfg_valid = 1'b1;
        cfg_div   = DIV_W'(div);
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clk_out"}, int'(clk_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cur_div"}, int'(cur_div), DEF_DIV);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_upd_done"}, int'(upd_done), 0);
    endtask

    initial begin
        rst = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk_in); #1;
        rst = 1'b0;
        cycles(3);

        // Default ratio 7 from reset.
        run_en = 1'b1;
        cycles(22);

        // Ratio 4 requested mid-period at cnt 2.
        wait_k(2);
        offer(4);
        chk("ready_low_after_accept", int'(cfg_ready), 0);
        cycles(18);

        // Illegal ratio 1 is rejected; ratio 0 too.
        offer(1);
        cycles(6);
        offer(0);
        cycles(6);

        // Back to 7, then 5 offered exactly on the boundary cycle.
        offer(7);
        cycles(12);
        wait_k(6);
        offer(5);
        cycles(20);

        // Stop at cnt 1 and drain to idle.
        wait_k(1);
        run_en = 1'b0;
        cycles(10);
        chk("idle_after_drain", int'(busy), 0);

        // Restart, then a short run_en dip during drain keeps output continuous.
        run_en = 1'b1;
        cycles(3);
        run_en = 1'b0;
        cyc();
        run_en = 1'b1;
        cycles(12);

        // Ratio change while idle, then extremes 2 and 15.
        run_en = 1'b0;
        cycles(8);
        offer(2);
        cycles(2);
        run_en = 1'b1;
        cycles(10);
        offer(15);
        cycles(34);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 24) == 0) run_en = ~run_en;
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div   = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
            cyc();
        end
        cfg_valid = 1'b0;

        // Reset asserted during a high phase truncates the output at once.
        run_en = 1'b1;
        offer(6);
        for (int i = 0; i < 60 && exp_clk(1) == 0; i++) cyc();
        chk("high_phase_found", exp_clk(1), 1);
        chk("high_before_reset", int'(clk_out), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(negedge clk_in); #1;
        rst = 1'b0;
        run_en = 1'b0;
        cycles(2);
        run_en = 1'b1;
        cycles(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
